// File: rtl/vga_rx_pkg.sv
// Shared VGA receiver definitions: FSM states, CRC constants and default
// timing that the text-mode generator also uses.
package vga_rx_pkg;

  typedef enum logic [1:0] {
    ST_SEARCH  = 2'd0,
    ST_MEASURE = 2'd1,
    ST_LOCKED  = 2'd2
  } rx_state_t;

  localparam logic [15:0] CRC_POLY = 16'h1021;
  localparam logic [15:0] CRC_INIT = 16'hFFFF;

  localparam int DEF_CLK_DIV  = 2;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_START  = 144;
  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_TOTAL  = 800;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_START  = 35;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_TOTAL  = 525;

  // CRC-16-CCITT over one byte, MSB first.
  function automatic logic [15:0] crc16_byte(input logic [15:0] crc, input logic [7:0] data);
    logic [15:0] c;
    c = crc;
    for (int i = 7; i >= 0; i--) begin
      if (c[15] ^ data[i]) c = {c[14:0], 1'b0} ^ CRC_POLY;
      else                 c = {c[14:0], 1'b0};
    end
    return c;
  endfunction

endpackage

// File: rtl/vga_rx_sync.sv
// Two-flop synchronizer for one sync input plus assertion-edge detect.
// The edge is judged against the level seen at the previous pixel strobe.
module vga_rx_sync #(
  parameter bit POL = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic stb,
  input  logic din,
  output logic act_edge
);

  logic s1, s2, prev;

  always_ff @(posedge clk) begin
    if (!reset) begin
      s1   <= 1'b0;
      s2   <= 1'b0;
      prev <= 1'b0;
    end else begin
      s1 <= din;
      s2 <= s1;
      if (stb) prev <= s2;
    end
  end

  assign act_edge = stb && (s2 == POL) && (prev != POL);

endmodule

// File: rtl/vga_sync_receiver.sv
// VGA receive decoder: measures line/frame timing, locks, and emits x/y/rgb per active pixel.
// Define VGA_RX_CRC_EN to compute a per-frame CRC-16 of the pixel stream on frame_crc.
module vga_sync_receiver
  import vga_rx_pkg::*;
#(
  parameter int CLK_DIV     = DEF_CLK_DIV,
  parameter int HCNT_W      = 10,
  parameter int VCNT_W      = 10,
  parameter int H_START     = DEF_H_START,
  parameter int V_START     = DEF_V_START,
  parameter int H_ACTIVE    = DEF_H_ACTIVE,
  parameter int V_ACTIVE    = DEF_V_ACTIVE,
  parameter int LOCK_FRAMES = 2,
  parameter bit SYNC_POL    = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              h_sync,
  input  logic              v_sync,
  input  logic              red,
  input  logic              green,
  input  logic              blue,
  output logic              px_valid,
  output logic [HCNT_W-1:0] px_x,
  output logic [VCNT_W-1:0] px_y,
  output logic [2:0]        px_rgb,
  output logic              locked,
  output logic              frame_start,
  output logic [HCNT_W-1:0] line_len,
  output logic [VCNT_W-1:0] frame_lines,
  output logic              timing_err,
  output logic [15:0]       frame_crc
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam int GC_W = $clog2(LOCK_FRAMES + 1);
  localparam logic [GC_W-1:0] GC_LOCK = GC_W'(LOCK_FRAMES - 1);

  localparam logic [HCNT_W-1:0] H_MAX = '1;
  localparam logic [VCNT_W-1:0] V_MAX = '1;
  localparam logic [HCNT_W-1:0] H_LO  = HCNT_W'(H_START);
  localparam logic [HCNT_W-1:0] H_HI  = HCNT_W'(H_START + H_ACTIVE);
  localparam logic [VCNT_W-1:0] V_LO  = VCNT_W'(V_START);
  localparam logic [VCNT_W-1:0] V_HI  = VCNT_W'(V_START + V_ACTIVE);

  logic [DIV_W-1:0]  div_cnt;
  logic              pix_stb;
  logic              h_edge, v_edge;
  logic [2:0]        rgb_s1, rgb_s2;
  rx_state_t         state;
  logic [HCNT_W-1:0] hcnt, h_next, line_meas;
  logic [VCNT_W-1:0] vcnt, v_next, frame_meas;
  logic              h_sat, v_sat;
  logic              lines_ok;
  logic [GC_W-1:0]   good_cnt;
  logic              line_mis, frame_mis, frame_match, in_win;

  always_ff @(posedge clk) begin
    if (!reset)       div_cnt <= '0;
    else if (pix_stb) div_cnt <= '0;
    else              div_cnt <= div_cnt + 1'b1;
  end

  assign pix_stb = (div_cnt == DIV_LAST);

  vga_rx_sync #(.POL(SYNC_POL)) u_hsync (
    .clk(clk), .reset(reset), .stb(pix_stb), .din(h_sync), .act_edge(h_edge)
  );

  vga_rx_sync #(.POL(SYNC_POL)) u_vsync (
    .clk(clk), .reset(reset), .stb(pix_stb), .din(v_sync), .act_edge(v_edge)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      rgb_s1 <= '0;
      rgb_s2 <= '0;
    end else begin
      rgb_s1 <= {red, green, blue};
      rgb_s2 <= rgb_s1;
    end
  end

  // Counter values for the pixel being sampled at this strobe.
  always_comb begin
    h_next = hcnt;
    h_sat  = 1'b0;
    if (h_edge) begin
      h_next = '0;
    end else if (hcnt != H_MAX) begin
      h_next = hcnt + 1'b1;
      h_sat  = (hcnt == H_MAX - 1'b1);
    end
    v_next = vcnt;
    v_sat  = 1'b0;
    if (v_edge) begin
      v_next = '0;
    end else if (h_edge && vcnt != V_MAX) begin
      v_next = vcnt + 1'b1;
      v_sat  = (vcnt == V_MAX - 1'b1);
    end
  end

  assign line_meas   = hcnt + 1'b1;
  assign frame_meas  = vcnt + 1'b1;
  assign line_mis    = h_edge && (line_meas != line_len);
  assign frame_mis   = v_edge && (frame_meas != frame_lines);
  // The line closing on this strobe counts toward the frame closing with it.
  assign frame_match = lines_ok && !line_mis && !frame_mis;
  assign in_win      = (h_next >= H_LO) && (h_next < H_HI) && (v_next >= V_LO) && (v_next < V_HI);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state       <= ST_SEARCH;
      hcnt        <= '0;
      vcnt        <= '0;
      line_len    <= '0;
      frame_lines <= '0;
      lines_ok    <= 1'b0;
      good_cnt    <= '0;
      locked      <= 1'b0;
      frame_start <= 1'b0;
      timing_err  <= 1'b0;
      px_valid    <= 1'b0;
      px_x        <= '0;
      px_y        <= '0;
      px_rgb      <= '0;
    end else begin
      frame_start <= 1'b0;
      timing_err  <= 1'b0;
      px_valid    <= 1'b0;
      if (pix_stb) begin
        hcnt <= h_next;
        vcnt <= v_next;
        if (h_edge)   line_len    <= line_meas;
        if (v_edge)   frame_lines <= frame_meas;
        if (line_mis) lines_ok    <= 1'b0;
        if (v_edge)   lines_ok    <= 1'b1;

        if (state == ST_LOCKED && in_win) begin
          px_valid <= 1'b1;
          px_x     <= h_next - H_LO;
          px_y     <= v_next - V_LO;
          px_rgb   <= rgb_s2;
        end

        case (state)
          ST_SEARCH: begin
            if (v_edge) begin
              state    <= ST_MEASURE;
              good_cnt <= '0;
            end
          end
          ST_MEASURE: begin
            if (v_edge) begin
              if (frame_match) begin
                good_cnt <= good_cnt + 1'b1;
                if (good_cnt >= GC_LOCK) begin
                  state  <= ST_LOCKED;
                  locked <= 1'b1;
                end
              end else begin
                // A mismatching frame becomes the new reference.
                good_cnt <= GC_W'(1);
              end
            end
          end
          ST_LOCKED: begin
            if (v_edge) frame_start <= 1'b1;
            if (line_mis || frame_mis) begin
              timing_err <= 1'b1;
              locked     <= 1'b0;
              state      <= ST_MEASURE;
              good_cnt   <= v_edge ? GC_W'(1) : '0;
            end
          end
          default: state <= ST_SEARCH;
        endcase

        if (h_sat || v_sat) begin
          timing_err <= 1'b1;
          locked     <= 1'b0;
          state      <= ST_SEARCH;
        end
      end
    end
  end

`ifdef VGA_RX_CRC_EN
  logic [15:0] crc_acc;

  always_ff @(posedge clk) begin
    if (!reset) begin
      crc_acc   <= CRC_INIT;
      frame_crc <= '0;
    end else if (pix_stb && v_edge && state == ST_LOCKED) begin
      frame_crc <= crc_acc;
      crc_acc   <= CRC_INIT;
    end else if (px_valid) begin
      crc_acc <= crc16_byte(crc_acc, {5'b0, px_rgb});
    end
  end
`else
  assign frame_crc = '0;
`endif

endmodule

// File: tb/tb_vga_sync_receiver.sv
// Directed bench for vga_sync_receiver on a reduced 20x10 pixel raster
// (3-pixel hsync, 2-line vsync, 8x4 active window at column 4, row 2).
module tb_vga_sync_receiver;

  localparam int LINE  = 20;
  localparam int HS_W  = 3;
  localparam int LINES = 10;
  localparam int VS_W  = 2;
  localparam int HST   = 4;
  localparam int VST   = 2;
  localparam int HACT  = 8;
  localparam int VACT  = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       h_sync = 1'b0, v_sync = 1'b0;
  logic       red = 1'b0, green = 1'b0, blue = 1'b0;
  logic       px_valid, locked, frame_start, timing_err;
  logic [9:0] px_x, line_len;
  logic [9:0] px_y, frame_lines;
  logic [2:0] px_rgb;
  logic [15:0] frame_crc;

  vga_sync_receiver #(
    .CLK_DIV(2), .HCNT_W(10), .VCNT_W(10), .H_START(HST), .V_START(VST),
    .H_ACTIVE(HACT), .V_ACTIVE(VACT), .LOCK_FRAMES(2), .SYNC_POL(1'b1)
  ) dut (
    .clk(clk), .reset(reset), .h_sync(h_sync), .v_sync(v_sync),
    .red(red), .green(green), .blue(blue),
    .px_valid(px_valid), .px_x(px_x), .px_y(px_y), .px_rgb(px_rgb),
    .locked(locked), .frame_start(frame_start), .line_len(line_len),
    .frame_lines(frame_lines), .timing_err(timing_err), .frame_crc(frame_crc)
  );

  always #10 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int drv_cyc = 0;
  int pv_cnt = 0, col_cnt = 0, err_cnt = 0, fs_cnt = 0;
  int col_x = 0, col_y = 0, col_rgb = 0, col_cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (px_valid) begin
      pv_cnt++;
      if (px_rgb != 3'b000) begin
        col_cnt++;
        col_x   = int'(px_x);
        col_y   = int'(px_y);
        col_rgb = int'(px_rgb);
        col_cyc = cyc;
      end
    end
    if (timing_err)  err_cnt++;
    if (frame_start) fs_cnt++;
  end

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // One pixel period: drive at a negedge, hold for CLK_DIV clocks.
  task automatic px(input logic h, input logic v, input logic [2:0] rgb);
    h_sync = h;
    v_sync = v;
    {red, green, blue} = rgb;
    if (rgb != 3'b000) drv_cyc = cyc;
    repeat (2) @(negedge clk);
  endtask

  task automatic send_line(input int ln, input int p0, input int p1, input int red_px, input int red_ln);
    for (int p = p0; p < p1; p++)
      px(p < HS_W, ln < VS_W, (p == red_px && ln == red_ln) ? 3'b100 : 3'b000);
  endtask

  task automatic send_frame(input int long_ln, input int red_px, input int red_ln);
    for (int l = 0; l < LINES; l++)
      send_line(l, 0, (l == long_ln) ? 24 : LINE, red_px, red_ln);
  endtask

  function automatic int crc_zero_bytes(input int n);
    logic [15:0] c;
    logic [7:0]  b;
    c = 16'hFFFF;
    b = 8'h00;
    for (int i = 0; i < n; i++) begin
      c = c ^ {b, 8'h00};
      for (int k = 0; k < 8; k++)
        c = c[15] ? ((c << 1) ^ 16'h1021) : (c << 1);
    end
    return int'(c);
  endfunction

  int pv0, c0, f0, e0, exp_crc;

  initial begin
    repeat (4) @(negedge clk);
    chk("rst_locked", int'(locked), 0);
    chk("rst_px_valid", int'(px_valid), 0);
    chk("rst_line_len", int'(line_len), 0);
    chk("rst_frame_lines", int'(frame_lines), 0);
    chk("rst_timing_err", int'(timing_err), 0);
    chk("rst_frame_start", int'(frame_start), 0);
    chk("rst_frame_crc", int'(frame_crc), 0);
    reset = 1'b1;

    // Lock acquisition: third vsync edge.
    send_frame(-1, -1, -1);
    send_frame(-1, -1, -1);
    chk("lock_edge2", int'(locked), 0);
    chk("line_len", int'(line_len), LINE);
    chk("frame_lines", int'(frame_lines), LINES);
    send_frame(-1, -1, -1);
    chk("lock_edge3", int'(locked), 1);

    // Single red pixel at the first active position.
    pv0 = pv_cnt; c0 = col_cnt; f0 = fs_cnt;
    send_frame(-1, HST, VST);
    chk("red_count", col_cnt - c0, 1);
    chk("red_x", col_x, 0);
    chk("red_y", col_y, 0);
    chk("red_rgb", col_rgb, 4);
    chk("red_latency", col_cyc - drv_cyc - 1, 3);
    chk("valid_per_frame", pv_cnt - pv0, HACT * VACT);
    chk("frame_start_cnt", fs_cnt - f0, 1);

    // One long line while locked.
    e0 = err_cnt;
    send_frame(3, -1, -1);
    chk("long_line_err", err_cnt - e0, 1);
    chk("long_line_unlock", int'(locked), 0);
    send_frame(-1, -1, -1);
    chk("relock_early", int'(locked), 0);
    send_frame(-1, -1, -1);
    send_frame(-1, -1, -1);
    chk("relock", int'(locked), 1);
    chk("relock_err_total", err_cnt - e0, 1);

    // Hsync stuck deasserted: hcnt saturates.
    e0 = err_cnt;
    px(1'b1, 1'b1, 3'b000);
    for (int i = 0; i < 1100; i++) px(1'b0, 1'b0, 3'b000);
    chk("sat_err", err_cnt - e0, 1);
    chk("sat_unlock", int'(locked), 0);
    send_frame(-1, -1, -1);
    send_frame(-1, -1, -1);
    chk("sat_edge2", int'(locked), 0);
    send_frame(-1, -1, -1);
    chk("sat_edge3", int'(locked), 1);

    // One-clock reset in the middle of the active area.
    for (int l = 0; l < 5; l++) send_line(l, 0, LINE, -1, -1);
    send_line(5, 0, 8, -1, -1);
    chk("pre_reset_x", int'(px_x != 10'd0), 1);
    reset = 1'b0;
    @(negedge clk);
    chk("mid_rst_locked", int'(locked), 0);
    chk("mid_rst_px_x", int'(px_x), 0);
    chk("mid_rst_px_y", int'(px_y), 0);
    chk("mid_rst_line_len", int'(line_len), 0);
    chk("mid_rst_frame_lines", int'(frame_lines), 0);
    reset = 1'b1;
    send_line(5, 8, LINE, -1, -1);
    for (int l = 6; l < LINES; l++) send_line(l, 0, LINE, -1, -1);
    send_frame(-1, -1, -1);
    send_frame(-1, -1, -1);
    chk("rst_relock_edge2", int'(locked), 0);
    send_frame(-1, -1, -1);
    chk("rst_relock_edge3", int'(locked), 1);

    // Black frame CRC.
    send_frame(-1, -1, -1);
    send_frame(-1, -1, -1);
`ifdef VGA_RX_CRC_EN
    exp_crc = crc_zero_bytes(HACT * VACT);
`else
    exp_crc = 0;
`endif
    chk("frame_crc", int'(frame_crc), exp_crc);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
